pe_simd_mac: RTL

PE_SIMD_MAC -- requirements
Module: pe_simd_mac

---
 rtl/pe_simd_mac.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pe_simd_mac.sv
// SIMD multiply-accumulate processing element: INT8/INT16 lanes, two-stage
// product/accumulate pipeline, packet framing with a ready/valid result port.
module pe_simd_mac #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ACC_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic                        is_signed,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_a,
    input  logic [DATA_W-1:0]           in_b,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [(DATA_W/8)*ACC_W-1:0] out_acc,
    output logic [DATA_W/8-1:0]         out_ovf
);

    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned HALF   = LANES / 2;
    localparam int unsigned OP_W   = 17;
    localparam int unsigned PROD_W = 34;
    localparam int unsigned SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 2;

    localparam logic signed [SUM_W-1:0] ONE  = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SMAX = (ONE <<< (ACC_W - 1)) - ONE;
    localparam logic signed [SUM_W-1:0] SMIN = -(ONE <<< (ACC_W - 1));
    localparam logic signed [SUM_W-1:0] UMAX = (ONE <<< ACC_W) - ONE;

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_FLUSH = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic                          beat;
    logic                          first_q;
    logic                          mode_q;
    logic                          sign_q;
    logic                          eff_mode;
    logic                          eff_sign;
    logic                          s2_valid;
    logic                          s2_first;
    logic [LANES-1:0][PROD_W-1:0]  prod_c;
    logic [LANES-1:0][PROD_W-1:0]  prod_q;
    logic [LANES-1:0][ACC_W-1:0]   acc_q;
    logic [LANES-1:0][ACC_W-1:0]   acc_nx;
    logic [LANES-1:0]              ovf_q;
    logic [LANES-1:0]              ovf_nx;

    assign beat = in_valid & in_ready;

    // The first beat of a packet uses the live mode/sign; later beats use the latched copy.
    assign eff_mode = first_q ? mode : mode_q;
    assign eff_sign = first_q ? is_signed : sign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ACC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_ACC:   if (beat && in_last) state_nx = S_FLUSH;
            S_FLUSH: state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = S_ACC;
            default: state_nx = S_ACC;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_ACC:   in_ready  = ~rst;
            S_OUT:   out_valid = 1'b1;
            default: ;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [OP_W-1:0] a8;
        logic signed [OP_W-1:0] b8;
        logic signed [OP_W-1:0] a16;
        logic signed [OP_W-1:0] b16;
        logic signed [OP_W-1:0] op_a;
        logic signed [OP_W-1:0] op_b;

        assign a8 = {{(OP_W-8){eff_sign & in_a[8*i+7]}}, in_a[8*i +: 8]};
        assign b8 = {{(OP_W-8){eff_sign & in_b[8*i+7]}}, in_b[8*i +: 8]};

        // Lanes beyond the INT16 lane count contribute zero in INT16 mode.
        if (i < HALF) begin : g_wide
            assign a16 = {eff_sign & in_a[16*i+15], in_a[16*i +: 16]};
            assign b16 = {eff_sign & in_b[16*i+15], in_b[16*i +: 16]};
        end else begin : g_narrow
            assign a16 = '0;
            assign b16 = '0;
        end

        assign op_a      = eff_mode ? a16 : a8;
        assign op_b      = eff_mode ? b16 : b8;
        assign prod_c[i] = PROD_W'(op_a) * PROD_W'(op_b);
    end

    // Stage 1: capture products and packet framing on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            first_q  <= 1'b1;
            mode_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            s2_valid <= beat;
            if (beat) begin
                prod_q   <= prod_c;
                s2_first <= first_q;
                first_q  <= in_last;
                if (first_q) begin
                    mode_q <= mode;
                    sign_q <= is_signed;
                end
            end
        end
    end

    // Stage 2 arithmetic: full-precision sum, range check, clamp or wrap.
    always_comb begin
        logic signed [SUM_W-1:0] lim_hi;
        logic signed [SUM_W-1:0] lim_lo;
        logic signed [SUM_W-1:0] acc_ext;
        logic signed [SUM_W-1:0] sum;
        acc_nx  = acc_q;
        ovf_nx  = ovf_q;
        lim_hi  = sign_q ? SMAX : UMAX;
        lim_lo  = sign_q ? SMIN : '0;
        acc_ext = '0;
        sum     = '0;
        for (int i = 0; i < LANES; i++) begin
            acc_ext = s2_first ? '0 :
                      {{(SUM_W-ACC_W){sign_q & acc_q[i][ACC_W-1]}}, acc_q[i]};
            sum     = acc_ext + SUM_W'($signed(prod_q[i]));
            ovf_nx[i] = s2_first ? 1'b0 : ovf_q[i];
            if (sum > lim_hi) begin
                ovf_nx[i] = 1'b1;
                acc_nx[i] = SATURATE ? lim_hi[ACC_W-1:0] : sum[ACC_W-1:0];
            end else if (sum < lim_lo) begin
                ovf_nx[i] = 1'b1;
                acc_nx[i] = SATURATE ? lim_lo[ACC_W-1:0] : sum[ACC_W-1:0];
            end else begin
                acc_nx[i] = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= '0;
        end else begin
            if (beat && first_q) begin
                ovf_q <= '0;
            end
            if (s2_valid) begin
                acc_q <= acc_nx;
                ovf_q <= ovf_nx;
            end
        end
    end

    assign out_acc = acc_q;
    assign out_ovf = ovf_q;

endmodule
